// File: rtl/gemm_sched_if.sv
// rtl/gemm_sched_if.sv - command, bank-load and execution handshakes of the GEMM tile scheduler
interface gemm_sched_if #(
    parameter int TW = 8
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic [TW-1:0] cmd_ntile;
    logic          ld_req;
    logic          ld_buf;
    logic          ld_done;
    logic          ex_init;
    logic          ex_buf;
    logic          ex_fin;
    logic          busy;
    logic          done;
    logic [TW-1:0] tile_cnt;

    modport slave (
        input  cmd_valid, cmd_ntile, ld_done, ex_fin,
        output cmd_ready, ld_req, ld_buf, ex_init, ex_buf, busy, done, tile_cnt
    );

    modport master (
        output cmd_valid, cmd_ntile, ld_done, ex_fin,
        input  cmd_ready, ld_req, ld_buf, ex_init, ex_buf, busy, done, tile_cnt
    );
endinterface

// File: rtl/gemm_sched.sv
// rtl/gemm_sched.sv - ping-pong tile scheduler: overlaps bank load of tile t+1 with execution of tile t
module gemm_sched #(
    parameter int TW = 8
) (
    input  logic         clk,
    input  logic         rst,
    gemm_sched_if.slave  bus
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] ntile_q, ntile_d;
    logic [TW-1:0] issued_q, issued_d;
    logic [TW-1:0] tile_cnt_q, tile_cnt_d;
    logic [1:0]    full_q, full_d;
    logic          ld_buf_q, ld_buf_d;
    logic          ex_buf_q, ex_buf_d;
    logic          ld_out_q, ld_out_d;
    logic          ex_run_q, ex_run_d;
    logic          ld_req_q, ld_req_d;
    logic          ex_init_q, ex_init_d;
    logic          done_q, done_d;

    // Issue decisions look at next-state bookkeeping so completions free a bank in the very next cycle.
    always_comb begin
        state_d    = state_q;
        ntile_d    = ntile_q;
        issued_d   = issued_q;
        tile_cnt_d = tile_cnt_q;
        full_d     = full_q;
        ld_buf_d   = ld_buf_q;
        ex_buf_d   = ex_buf_q;
        ld_out_d   = ld_out_q;
        ex_run_d   = ex_run_q;
        ld_req_d   = 1'b0;
        ex_init_d  = 1'b0;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    if (bus.cmd_ntile == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d    = RUN;
                        ntile_d    = bus.cmd_ntile;
                        issued_d   = '0;
                        tile_cnt_d = '0;
                        full_d     = 2'b00;
                        ld_buf_d   = 1'b0;
                        ex_buf_d   = 1'b0;
                        ld_out_d   = 1'b0;
                        ex_run_d   = 1'b0;
                    end
                end
            end
            RUN: begin
                if (bus.ld_done && ld_out_q) begin
                    full_d[ld_buf_q] = 1'b1;
                    ld_buf_d         = ~ld_buf_q;
                    ld_out_d         = 1'b0;
                end
                if (bus.ex_fin && ex_run_q) begin
                    full_d[ex_buf_q] = 1'b0;
                    ex_buf_d         = ~ex_buf_q;
                    ex_run_d         = 1'b0;
                    tile_cnt_d       = tile_cnt_q + TW'(1);
                    if (tile_cnt_d == ntile_q) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_d == RUN) begin
            if ((issued_d < ntile_d) && !ld_out_d && !full_d[ld_buf_d]) begin
                ld_req_d = 1'b1;
                ld_out_d = 1'b1;
                issued_d = issued_d + TW'(1);
            end
            if (!ex_run_d && full_d[ex_buf_d]) begin
                ex_init_d = 1'b1;
                ex_run_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            ntile_q    <= '0;
            issued_q   <= '0;
            tile_cnt_q <= '0;
            full_q     <= 2'b00;
            ld_buf_q   <= 1'b0;
            ex_buf_q   <= 1'b0;
            ld_out_q   <= 1'b0;
            ex_run_q   <= 1'b0;
            ld_req_q   <= 1'b0;
            ex_init_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ntile_q    <= ntile_d;
            issued_q   <= issued_d;
            tile_cnt_q <= tile_cnt_d;
            full_q     <= full_d;
            ld_buf_q   <= ld_buf_d;
            ex_buf_q   <= ex_buf_d;
            ld_out_q   <= ld_out_d;
            ex_run_q   <= ex_run_d;
            ld_req_q   <= ld_req_d;
            ex_init_q  <= ex_init_d;
            done_q     <= done_d;
        end
    end

    assign bus.cmd_ready = (state_q == IDLE);
    assign bus.busy      = (state_q == RUN);
    assign bus.ld_req    = ld_req_q;
    assign bus.ld_buf    = ld_buf_q;
    assign bus.ex_init   = ex_init_q;
    assign bus.ex_buf    = ex_buf_q;
    assign bus.done      = done_q;
    assign bus.tile_cnt  = tile_cnt_q;

    a_ld_to_empty: assert property (@(posedge clk) disable iff (rst) ld_req_q |-> !full_q[ld_buf_q]);
    a_ex_on_full:  assert property (@(posedge clk) disable iff (rst) ex_init_q |-> full_q[ex_buf_q]);
    a_issue_bound: assert property (@(posedge clk) disable iff (rst) issued_q <= ntile_q);
endmodule

// File: tb/tb_gemm_sched.sv
// tb/tb_gemm_sched.sv - directed self-checking bench for gemm_sched
module tb_gemm_sched;
    localparam int TW = 8;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;
    int   cyc;
    int   n_ld;
    int   n_ex;
    int   snap_ld;
    int   snap_ex;
    logic hold_cmd;

    gemm_sched_if #(.TW(TW)) bus ();

    gemm_sched #(.TW(TW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.ld_req)  n_ld++;
            if (bus.ex_init) n_ex++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        bus.ld_done = 1'b0;
        bus.ex_fin  = 1'b0;
        if (!hold_cmd) bus.cmd_valid = 1'b0;
    endtask

    task automatic go(input int n);
        while (cyc < n) tick();
    endtask

    task automatic accept(input int n);
        bus.cmd_ntile = TW'(n);
        bus.cmd_valid = 1'b1;
        cyc = 0;
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; cyc = 0; n_ld = 0; n_ex = 0; hold_cmd = 1'b0;
        bus.cmd_valid = 1'b0; bus.cmd_ntile = '0; bus.ld_done = 1'b0; bus.ex_fin = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cmd_ready", bus.cmd_ready, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_ld_req", bus.ld_req, 0);
        chk("rst_ex_init", bus.ex_init, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_bufs", {bus.ld_buf, bus.ex_buf}, 0);
        chk("rst_tile_cnt", bus.tile_cnt, 0);
        rst = 1'b0;
        tick();

        // 1: single tile
        accept(1);
        tick();
        chk("t1_ld_req", bus.ld_req, 1);
        chk("t1_ld_buf", bus.ld_buf, 0);
        chk("t1_busy", bus.busy, 1);
        chk("t1_cmd_ready", bus.cmd_ready, 0);
        go(4); bus.ld_done = 1'b1;
        chk("t1_no_ex_before", bus.ex_init, 0);
        tick();
        chk("t1_ex_init", bus.ex_init, 1);
        chk("t1_ex_buf", bus.ex_buf, 0);
        chk("t1_no_ld2", bus.ld_req, 0);
        go(40); bus.ex_fin = 1'b1;
        tick();
        chk("t1_done", bus.done, 1);
        chk("t1_tile_cnt", bus.tile_cnt, 1);
        chk("t1_cmd_ready", bus.cmd_ready, 1);
        chk("t1_busy_off", bus.busy, 0);
        tick();
        chk("t1_done_pulse", bus.done, 0);

        // 2: three tiles, third load waits for bank 0 to drain
        accept(3);
        tick();
        chk("t2_ld1", {bus.ld_req, bus.ld_buf}, 2'b10);
        go(4); bus.ld_done = 1'b1;
        tick();
        chk("t2_ld2", {bus.ld_req, bus.ld_buf}, 2'b11);
        chk("t2_ex1", {bus.ex_init, bus.ex_buf}, 2'b10);
        go(8); bus.ld_done = 1'b1;
        tick();
        snap_ld = n_ld;
        chk("t2_ld_buf_wrap", bus.ld_buf, 0);
        go(20); bus.ex_fin = 1'b1;
        chk("t2_ld3_held", n_ld - snap_ld, 0);
        tick();
        chk("t2_ld3", {bus.ld_req, bus.ld_buf}, 2'b10);
        chk("t2_ex2", {bus.ex_init, bus.ex_buf}, 2'b11);
        chk("t2_cnt1", bus.tile_cnt, 1);
        go(24); bus.ld_done = 1'b1;
        go(30); bus.ex_fin = 1'b1;
        tick();
        chk("t2_ex3", {bus.ex_init, bus.ex_buf}, 2'b10);
        chk("t2_cnt2", bus.tile_cnt, 2);
        chk("t2_no_ld4", bus.ld_req, 0);
        go(40); bus.ex_fin = 1'b1;
        tick();
        chk("t2_done", {bus.done, bus.busy}, 2'b10);
        chk("t2_cnt3", bus.tile_cnt, 3);
        tick();

        // 3: ld_done and ex_fin together
        accept(3);
        go(4); bus.ld_done = 1'b1;
        tick();
        chk("t3_ld2", {bus.ld_req, bus.ld_buf}, 2'b11);
        go(8); bus.ld_done = 1'b1; bus.ex_fin = 1'b1;
        tick();
        chk("t3_ex_new", {bus.ex_init, bus.ex_buf}, 2'b11);
        chk("t3_ld_freed", {bus.ld_req, bus.ld_buf}, 2'b10);
        chk("t3_cnt", bus.tile_cnt, 1);
        go(12); bus.ld_done = 1'b1;
        go(15); bus.ex_fin = 1'b1;
        tick();
        chk("t3_ex3", {bus.ex_init, bus.ex_buf}, 2'b10);
        go(20); bus.ex_fin = 1'b1;
        tick();
        chk("t3_done", bus.done, 1);
        chk("t3_cnt3", bus.tile_cnt, 3);
        tick();

        // 4: empty command
        snap_ld = n_ld; snap_ex = n_ex;
        accept(0);
        tick();
        chk("t4_done", bus.done, 1);
        chk("t4_cmd_ready", bus.cmd_ready, 1);
        chk("t4_busy", bus.busy, 0);
        go(5);
        chk("t4_no_ld", n_ld - snap_ld, 0);
        chk("t4_no_ex", n_ex - snap_ex, 0);
        chk("t4_done_pulse", bus.done, 0);

        // 5: cmd_valid held in RUN, spurious completions
        hold_cmd = 1'b1;
        accept(2);
        tick();
        bus.cmd_ntile = TW'(5);
        chk("t5_cmd_ready", bus.cmd_ready, 0);
        go(4); bus.ld_done = 1'b1;
        tick();
        chk("t5_ld2", {bus.ld_req, bus.ld_buf}, 2'b11);
        go(8); bus.ex_fin = 1'b1;
        tick();
        chk("t5_cnt1", bus.tile_cnt, 1);
        go(10); bus.ex_fin = 1'b1;
        tick();
        chk("t5_spur_ex", {bus.ex_init, bus.ex_buf, bus.tile_cnt}, {1'b0, 1'b1, 8'd1});
        go(12); bus.ld_done = 1'b1;
        tick();
        chk("t5_ex2", {bus.ex_init, bus.ex_buf}, 2'b11);
        chk("t5_ld_buf", bus.ld_buf, 0);
        go(14); bus.ld_done = 1'b1;
        tick();
        chk("t5_spur_ld", {bus.ld_buf, bus.ld_req}, 2'b00);
        chk("t5_still_busy", bus.cmd_ready, 0);
        go(18); bus.ex_fin = 1'b1;
        tick();
        hold_cmd = 1'b0;
        bus.cmd_valid = 1'b0;
        chk("t5_done", bus.done, 1);
        chk("t5_no_relatch", bus.tile_cnt, 2);
        tick();
        chk("t5_idle", bus.busy, 0);

        // 6: reset mid-run, then a clean command
        accept(3);
        go(4); bus.ld_done = 1'b1;
        go(8); bus.ld_done = 1'b1;
        go(10); bus.ex_fin = 1'b1;
        tick();
        chk("t6_pre_cnt", bus.tile_cnt, 1);
        chk("t6_pre_bufs", {bus.ld_buf, bus.ex_buf}, 2'b01);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_ready", {bus.cmd_ready, bus.busy}, 2'b10);
        chk("t6_rst_pulses", {bus.ld_req, bus.ex_init, bus.done}, 3'b000);
        chk("t6_rst_bufs", {bus.ld_buf, bus.ex_buf}, 2'b00);
        chk("t6_rst_cnt", bus.tile_cnt, 0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        accept(2);
        tick();
        chk("t6_ld1", {bus.ld_req, bus.ld_buf}, 2'b10);
        go(3); bus.ld_done = 1'b1;
        tick();
        chk("t6_ex1", {bus.ex_init, bus.ex_buf, bus.ld_req}, 3'b101);
        go(6); bus.ld_done = 1'b1;
        go(8); bus.ex_fin = 1'b1;
        tick();
        chk("t6_ex2", {bus.ex_init, bus.ex_buf}, 2'b11);
        go(12); bus.ex_fin = 1'b1;
        tick();
        chk("t6_done", bus.done, 1);
        chk("t6_cnt", bus.tile_cnt, 2);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
